mmcme2_base: RTL and testbench
==============================

// Module: mmcme2_base
// PURPOSE
//   Synthesizable behavioural clock manager modelled on the 7-series MMCM base primitive.
//   clk_i is treated as the VCO-rate clock; seven outputs and a feedback clock are integer divisions of it.
//   Each output has its own high time and phase, plus optional CLKOUT4 cascade, lock detection and power-down.
//   Sits in the FPGA clocking path and feeds bus and peripheral clock domains.
// PARAMETERS
//   CLKFBOUT_DIVIDE  2         feedback clock divide (2..128)
//   CLKOUTn_DIVIDE   2         n=0..6; output divide in clk_i cycles (2..128)
//   CLKOUTn_HIGH     DIVIDE/2  n=0..6; high cycles per period (1..DIVIDE-1)
//   CLKOUTn_PHASE    0         n=0..6; delay in clk_i cycles (0..DIVIDE-1)
//   CLKOUT4_CASCADE  0         1: CLKOUT4 counter advances only on CLKOUT6 period starts
//   LOCK_CYCLES      16        matching clk_i cycles required before locked asserts (>=1)
//   Out-of-range values must cause an elaboration error.
// PORTS
//   clk_i      in   1  VCO-rate input clock; all logic is on posedge
//   rst        in   1  synchronous, active-high reset
//   pwrdwn     in   1  synchronous power-down; same effect as rst
//   clkfbin    in   1  feedback input; normally wired to clkfbout
//   clkout0..6 out  1  divided clocks, registered
//   clkout0b..3b out 1 ~clkoutn while locked, else 0
//   clkfbout   out  1  feedback clock, registered
//   clkfboutb  out  1  ~clkfbout while locked, else 0
//   locked     out  1  1 = outputs running and phase-aligned
// BEHAVIOUR
//   - rst or pwrdwn high at an edge: locked, lock counter, all divide counters and all outputs go to 0.
//     rst has priority; both are equivalent.
//   - Lock phase (locked=0): outputs are held at 0.
//     At each edge, if clkfbin==clkfbout, lock_cnt increments; otherwise lock_cnt clears.
//     The edge at which lock_cnt would reach LOCK_CYCLES sets locked=1.
//     Result: locked rises on the LOCK_CYCLES-th edge after rst releases.
//   - Start edge (the edge locked goes 1): each counter cnt_n is loaded with s_n=(D_n-P_n)%D_n.
//     In the same edge, clkout_n <= (s_n < H_n). All outputs start together, so they are phase-aligned.
//   - Running: each edge, cnt_n <= (cnt_n+1)%D_n and clkout_n <= (cnt_n_next < H_n).
//     Period is D_n cycles; high for H_n cycles; phase P lags phase 0 by P cycles.
//   - clkfbout uses the same scheme with D=CLKFBOUT_DIVIDE, H=D/2, P=0.
//   - Cascade=1: cnt_4 advances only on edges where cnt_6_next==0.
//     CLKOUT4 period is then D4*D6 cycles, high for H4*D6 cycles.
//   - Loss of lock: while locked, if clkfbin!=clkfbout at an edge, then at that edge locked<=0, all outputs<=0,
//     counters<=0 and lock_cnt<=0; the full lock sequence then restarts.
//   - Counter width is 7 bits; wrap at D-1 -> 0. No glitches: every output changes only at posedge clk_i.
// TESTING
//   1. All defaults, clkfbin tied to clkfbout, rst for 3 cycles:
//      -> locked=1 exactly 16 edges after release; clkout0 then runs 1,0,1,0...
//   2. D0=4, H0=2, P0=0 and D1=4, H1=2, P1=1:
//      -> from lock, clkout0=1100 repeating; clkout1=0110 repeating; clkout1b=1001 repeating.
//   3. D2=5, H2=2:
//      -> clkout2=11000 repeating; the period measures exactly 5 clk_i cycles.
//   4. CLKOUT4_CASCADE=1, D4=2, H4=1, D6=3, H6=1:
//      -> clkout6=100 repeating; clkout4 high 3 cycles, low 3 cycles, with rises aligned to clkout6 rises.
//   5. After lock, force clkfbin to the inverse of clkfbout for 1 cycle:
//      -> next edge locked=0 and all outputs 0; locked re-asserts 16 matching edges later.
//   6. Assert pwrdwn mid-run for 2 cycles:
//      -> outputs and locked 0 at the first edge; after release, relock takes 16 edges with phase 0 restarting high.

Source files
------------

// File: rtl/mmcme2_base.sv
// Behavioural clock manager: seven divided outputs plus feedback clock, all derived from clk_i.
// Outputs stay low until the feedback loop has matched for LOCK_CYCLES edges, then start together.
module mmcme2_base #(
  parameter int CLKFBOUT_DIVIDE = 2,
  parameter int CLKOUT0_DIVIDE  = 2,
  parameter int CLKOUT1_DIVIDE  = 2,
  parameter int CLKOUT2_DIVIDE  = 2,
  parameter int CLKOUT3_DIVIDE  = 2,
  parameter int CLKOUT4_DIVIDE  = 2,
  parameter int CLKOUT5_DIVIDE  = 2,
  parameter int CLKOUT6_DIVIDE  = 2,
  parameter int CLKOUT0_HIGH    = CLKOUT0_DIVIDE / 2,
  parameter int CLKOUT1_HIGH    = CLKOUT1_DIVIDE / 2,
  parameter int CLKOUT2_HIGH    = CLKOUT2_DIVIDE / 2,
  parameter int CLKOUT3_HIGH    = CLKOUT3_DIVIDE / 2,
  parameter int CLKOUT4_HIGH    = CLKOUT4_DIVIDE / 2,
  parameter int CLKOUT5_HIGH    = CLKOUT5_DIVIDE / 2,
  parameter int CLKOUT6_HIGH    = CLKOUT6_DIVIDE / 2,
  parameter int CLKOUT0_PHASE   = 0,
  parameter int CLKOUT1_PHASE   = 0,
  parameter int CLKOUT2_PHASE   = 0,
  parameter int CLKOUT3_PHASE   = 0,
  parameter int CLKOUT4_PHASE   = 0,
  parameter int CLKOUT5_PHASE   = 0,
  parameter int CLKOUT6_PHASE   = 0,
  parameter int CLKOUT4_CASCADE = 0,
  parameter int LOCK_CYCLES     = 16
) (
  input  logic clk_i,
  input  logic rst,
  input  logic pwrdwn,
  input  logic clkfbin,
  output logic clkout0,
  output logic clkout1,
  output logic clkout2,
  output logic clkout3,
  output logic clkout4,
  output logic clkout5,
  output logic clkout6,
  output logic clkout0b,
  output logic clkout1b,
  output logic clkout2b,
  output logic clkout3b,
  output logic clkfbout,
  output logic clkfboutb,
  output logic locked
);

  // state   | meaning
  // ACQUIRE | outputs held low, counting matching feedback edges
  // RUN     | all dividers running, phase-aligned from the start edge

  localparam int NC  = 8;
  localparam int FB  = 7;
  localparam int LCW = $clog2(LOCK_CYCLES + 1);

  localparam int DIV [NC] = '{CLKOUT0_DIVIDE, CLKOUT1_DIVIDE, CLKOUT2_DIVIDE, CLKOUT3_DIVIDE,
                              CLKOUT4_DIVIDE, CLKOUT5_DIVIDE, CLKOUT6_DIVIDE, CLKFBOUT_DIVIDE};
  localparam int HI  [NC] = '{CLKOUT0_HIGH, CLKOUT1_HIGH, CLKOUT2_HIGH, CLKOUT3_HIGH,
                              CLKOUT4_HIGH, CLKOUT5_HIGH, CLKOUT6_HIGH, CLKFBOUT_DIVIDE / 2};
  localparam int PH  [NC] = '{CLKOUT0_PHASE, CLKOUT1_PHASE, CLKOUT2_PHASE, CLKOUT3_PHASE,
                              CLKOUT4_PHASE, CLKOUT5_PHASE, CLKOUT6_PHASE, 0};

  if (LOCK_CYCLES < 1) begin : g_bad_lock
    $error("mmcme2_base: LOCK_CYCLES must be >= 1");
  end
  if (CLKOUT4_CASCADE != 0 && CLKOUT4_CASCADE != 1) begin : g_bad_cascade
    $error("mmcme2_base: CLKOUT4_CASCADE must be 0 or 1");
  end
  for (genvar g = 0; g < NC; g++) begin : g_chk
    if (DIV[g] < 2 || DIV[g] > 128) begin : g_bad_div
      $error("mmcme2_base: divide out of range 2..128");
    end
    if (HI[g] < 1 || HI[g] > DIV[g] - 1) begin : g_bad_high
      $error("mmcme2_base: high time out of range 1..DIVIDE-1");
    end
    if (PH[g] < 0 || PH[g] > DIV[g] - 1) begin : g_bad_phase
      $error("mmcme2_base: phase out of range 0..DIVIDE-1");
    end
  end

  typedef enum logic {ACQUIRE, RUN} state_t;

  state_t           state;
  logic [6:0]       cnt     [NC];
  logic [6:0]       cnt_nxt [NC];
  logic [NC-1:0]    clk_q;
  logic [LCW-1:0]   lock_cnt;
  logic             fb_match;
  logic             cas_tick;

  assign fb_match = (clkfbin == clk_q[FB]);
  // counter 6 wraps to zero on this edge, i.e. a CLKOUT6 period starts
  assign cas_tick = (int'(cnt[6]) == DIV[6] - 1);

  always_comb begin
    for (int i = 0; i < NC; i++) begin
      cnt_nxt[i] = (int'(cnt[i]) == DIV[i] - 1) ? 7'd0 : cnt[i] + 7'd1;
    end
    if (CLKOUT4_CASCADE == 1 && !cas_tick) cnt_nxt[4] = cnt[4];
  end

  always_ff @(posedge clk_i) begin
    if (rst || pwrdwn || (state == RUN && !fb_match)) begin
      state    <= ACQUIRE;
      locked   <= 1'b0;
      lock_cnt <= '0;
      clk_q    <= '0;
      for (int i = 0; i < NC; i++) cnt[i] <= 7'd0;
    end else begin
      case (state)
        ACQUIRE: begin
          clk_q <= '0;
          if (!fb_match) begin
            lock_cnt <= '0;
          end else if (int'(lock_cnt) == LOCK_CYCLES - 1) begin
            state  <= RUN;
            locked <= 1'b1;
            for (int i = 0; i < NC; i++) begin
              cnt[i]   <= 7'((DIV[i] - PH[i]) % DIV[i]);
              clk_q[i] <= (((DIV[i] - PH[i]) % DIV[i]) < HI[i]);
            end
          end else begin
            lock_cnt <= lock_cnt + LCW'(1);
          end
        end
        RUN: begin
          for (int i = 0; i < NC; i++) begin
            cnt[i]   <= cnt_nxt[i];
            clk_q[i] <= (int'(cnt_nxt[i]) < HI[i]);
          end
        end
        default: state <= ACQUIRE;
      endcase
    end
  end

  assign clkout0   = clk_q[0];
  assign clkout1   = clk_q[1];
  assign clkout2   = clk_q[2];
  assign clkout3   = clk_q[3];
  assign clkout4   = clk_q[4];
  assign clkout5   = clk_q[5];
  assign clkout6   = clk_q[6];
  assign clkfbout  = clk_q[FB];
  assign clkout0b  = locked & ~clk_q[0];
  assign clkout1b  = locked & ~clk_q[1];
  assign clkout2b  = locked & ~clk_q[2];
  assign clkout3b  = locked & ~clk_q[3];
  assign clkfboutb = locked & ~clk_q[FB];

endmodule

// File: tb/tb_mmcme2_base.sv
// Bench for mmcme2_base: a configured instance and an all-default instance checked cycle by cycle
// against a behavioural model through a scoreboard queue, driven by a table of stimulus segments.
module tb_mmcme2_base;

  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic rst = 1'b1, pwrdwn = 1'b0, fb_force = 1'b0;

  logic clkfbin, clkout0, clkout1, clkout2, clkout3, clkout4, clkout5, clkout6;
  logic clkout0b, clkout1b, clkout2b, clkout3b, clkfbout, clkfboutb, locked;

  logic d_clkfbin, d_clkout0, d_clkout1, d_clkout2, d_clkout3, d_clkout4, d_clkout5, d_clkout6;
  logic d_clkout0b, d_clkout1b, d_clkout2b, d_clkout3b, d_clkfbout, d_clkfboutb, d_locked;

  assign clkfbin   = clkfbout ^ fb_force;
  assign d_clkfbin = d_clkfbout;

  mmcme2_base #(
    .CLKOUT0_DIVIDE(4), .CLKOUT0_HIGH(2), .CLKOUT0_PHASE(0),
    .CLKOUT1_DIVIDE(4), .CLKOUT1_HIGH(2), .CLKOUT1_PHASE(1),
    .CLKOUT2_DIVIDE(5), .CLKOUT2_HIGH(2),
    .CLKOUT4_DIVIDE(2), .CLKOUT4_HIGH(1),
    .CLKOUT6_DIVIDE(3), .CLKOUT6_HIGH(1),
    .CLKOUT4_CASCADE(1)
  ) u_cfg (
    .clk_i(clk_i), .rst(rst), .pwrdwn(pwrdwn), .clkfbin(clkfbin),
    .clkout0(clkout0), .clkout1(clkout1), .clkout2(clkout2), .clkout3(clkout3),
    .clkout4(clkout4), .clkout5(clkout5), .clkout6(clkout6),
    .clkout0b(clkout0b), .clkout1b(clkout1b), .clkout2b(clkout2b), .clkout3b(clkout3b),
    .clkfbout(clkfbout), .clkfboutb(clkfboutb), .locked(locked)
  );

  mmcme2_base u_def (
    .clk_i(clk_i), .rst(rst), .pwrdwn(1'b0), .clkfbin(d_clkfbin),
    .clkout0(d_clkout0), .clkout1(d_clkout1), .clkout2(d_clkout2), .clkout3(d_clkout3),
    .clkout4(d_clkout4), .clkout5(d_clkout5), .clkout6(d_clkout6),
    .clkout0b(d_clkout0b), .clkout1b(d_clkout1b), .clkout2b(d_clkout2b), .clkout3b(d_clkout3b),
    .clkfbout(d_clkfbout), .clkfboutb(d_clkfboutb), .locked(d_locked)
  );

  typedef struct {
    string name;
    int    cycles;
    bit    r;
    bit    pd;
    bit    frc;
    bit    exp_lk;
    bit    exp_dlk;
  } row_t;

  typedef struct {
    logic [13:0] cfg;
    logic [13:0] def;
  } exp_t;

  exp_t sb [$];
  row_t rows [12];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  bit m_lk = 0, d_lk = 0;
  int m_cnt = 0, m_t = 0, d_cnt = 0, d_t = 0;

  function automatic bit ck(int t, int d, int h, int p);
    return ((t + d - p) % d) < h;
  endfunction

  function automatic logic [13:0] pack(bit lk, bit fb, logic [6:0] c);
    if (!lk) return 14'd0;
    return {1'b1, fb, c, ~c[3:0], ~fb};
  endfunction

  function automatic logic [13:0] exp_cfg(bit lk, int t);
    logic [6:0] c;
    c[0] = ck(t, 4, 2, 0);
    c[1] = ck(t, 4, 2, 1);
    c[2] = ck(t, 5, 2, 0);
    c[3] = ck(t, 2, 1, 0);
    c[4] = ((t / 3) % 2) == 0;
    c[5] = ck(t, 2, 1, 0);
    c[6] = ck(t, 3, 1, 0);
    return pack(lk, ck(t, 2, 1, 0), c);
  endfunction

  function automatic logic [13:0] exp_def(bit lk, int t);
    logic [6:0] c;
    for (int i = 0; i < 7; i++) c[i] = ck(t, 2, 1, 0);
    return pack(lk, ck(t, 2, 1, 0), c);
  endfunction

  task automatic model_edge(inout bit lk, inout int cnt, inout int t, input bit clr, input bit mis);
    if (clr) begin
      lk = 0; cnt = 0; t = 0;
    end else if (!lk) begin
      if (mis) cnt = 0;
      else if (cnt == 15) begin lk = 1; t = 0; end
      else cnt++;
    end else if (mis) begin
      lk = 0; cnt = 0;
    end else begin
      t++;
    end
  endtask

  task automatic check(string nm, logic [13:0] act, logic [13:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s cycle=%0d actual=%b required=%b", nm, cyc, act, req);
    end
  endtask

  task automatic step(bit r, bit pd, bit frc);
    exp_t e;
    rst = r; pwrdwn = pd; fb_force = frc;
    model_edge(m_lk, m_cnt, m_t, r | pd, frc);
    model_edge(d_lk, d_cnt, d_t, r, 1'b0);
    e.cfg = exp_cfg(m_lk, m_t);
    e.def = exp_def(d_lk, d_t);
    sb.push_back(e);
    @(posedge clk_i); #1;
    e = sb.pop_front();
    check("cfg_outputs", {locked, clkfbout, clkout6, clkout5, clkout4, clkout3, clkout2, clkout1,
                          clkout0, clkout3b, clkout2b, clkout1b, clkout0b, clkfboutb}, e.cfg);
    check("def_outputs", {d_locked, d_clkfbout, d_clkout6, d_clkout5, d_clkout4, d_clkout3,
                          d_clkout2, d_clkout1, d_clkout0, d_clkout3b, d_clkout2b, d_clkout1b,
                          d_clkout0b, d_clkfboutb}, e.def);
    cyc++;
  endtask

  initial begin
    int  r1, r2, rises;
    logic prev2, prev4, prev6;

    rows[0]  = '{"reset",     3, 1, 0, 0, 0, 0};
    rows[1]  = '{"prelock",  15, 0, 0, 0, 0, 0};
    rows[2]  = '{"lock",      1, 0, 0, 0, 1, 1};
    rows[3]  = '{"run",      30, 0, 0, 0, 1, 1};
    rows[4]  = '{"fb_slip",   1, 0, 0, 1, 0, 1};
    rows[5]  = '{"reacq",    15, 0, 0, 0, 0, 1};
    rows[6]  = '{"relock",    1, 0, 0, 0, 1, 1};
    rows[7]  = '{"run2",     20, 0, 0, 0, 1, 1};
    rows[8]  = '{"pwrdwn",    2, 0, 1, 0, 0, 1};
    rows[9]  = '{"pd_reacq", 15, 0, 0, 0, 0, 1};
    rows[10] = '{"pd_relock", 1, 0, 0, 0, 1, 1};
    rows[11] = '{"run3",     10, 0, 0, 0, 1, 1};

    for (int i = 0; i < 12; i++) begin
      for (int k = 0; k < rows[i].cycles; k++) step(rows[i].r, rows[i].pd, rows[i].frc);
      check($sformatf("locked_after_%s", rows[i].name), {13'd0, locked}, {13'd0, rows[i].exp_lk});
      check($sformatf("def_locked_after_%s", rows[i].name), {13'd0, d_locked}, {13'd0, rows[i].exp_dlk});
    end

    // clkout2 rise-to-rise interval, bounded search
    r1 = -1; r2 = -1; prev2 = clkout2;
    for (int k = 0; k < 20 && r2 < 0; k++) begin
      step(0, 0, 0);
      if (clkout2 && !prev2) begin
        if (r1 < 0) r1 = k;
        else r2 = k;
      end
      prev2 = clkout2;
    end
    check("clkout2_period", 14'(r2 - r1), 14'd5);

    // cascaded clkout4 rises must coincide with clkout6 rises
    rises = 0; prev4 = clkout4; prev6 = clkout6;
    for (int k = 0; k < 12; k++) begin
      step(0, 0, 0);
      if (clkout4 && !prev4) begin
        rises++;
        check("clkout4_rise_on_clkout6_rise", {12'd0, clkout6, prev6}, 14'b10);
      end
      prev4 = clkout4; prev6 = clkout6;
    end
    check("clkout4_rises_in_12", 14'(rises), 14'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
